conv_pe_array_p: RTL and testbench
==================================

# conv_pe_array_p

Parametrised convolution PE array with N_CH filter channels × N_PE output positions and a K×K kernel. Kernel rows are streamed one per beat under a valid/ready handshake. An addressable partial-sum buffer accumulates results across input-channel passes, and the final pass adds bias, applies optional ReLU and saturates. The block sits between the line-buffer/window feeder and the pooling stage, in the same slot as the fixed 3×2×5×5 array of the current CNN datapath.

## Interface
Parameters:
- N_CH, 3: number of filter channels.
- N_PE, 2: output positions per channel, i.e. adjacent sliding windows.
- K, 5: kernel size (K×K).
- DW, 12: signed data width.
- WW, 8: signed weight and bias width.
- FRAC, 8: fixed-point right shift applied to each pass sum.
- OUT_W, 12: signed output width.
- BUF_W, 20: signed partial-sum buffer width.
- DEPTH, 16: partial-sum buffer entries. Each entry holds N_CH×N_PE values.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: asynchronous, active-high reset.
- clear_i, in, 1: synchronous abort of the pass in flight.
- relu_en_i, in, 1: enables ReLU on final results.
- in_valid_i, in, 1: input beat valid.
- in_ready_o, out, 1: beat accepted when in_valid_i && in_ready_o.
- data_i, in, (N_PE+K-1)×DW: one input row slice.
- weight_i, in, N_CH×K×K×WW: kernels, row-major per channel. Must be stable for the whole pass.
- bias_i, in, N_CH×WW: per-channel bias.
- first_i, in, 1: sideband, sampled on row 0 only. Pass starts from zero instead of the buffer contents.
- last_i, in, 1: sideband, sampled on row 0 only. Final pass: produce output, do not write the buffer.
- addr_i, in, clog2(DEPTH): sideband, sampled on row 0 only. Selects the buffer entry.
- out_valid_o, out, 1: output valid.
- out_ready_i, in, 1: output consumed when out_valid_o && out_ready_i.
- out_o, out, N_CH×N_PE×OUT_W: signed results.

## Operation
- Row counter `row` runs 0..K-1. It increments on each accepted beat and wraps to 0 after K-1. One pass is K accepted beats.
- S1 (MAC): on an accepted beat, for each channel c and position p, register `rs[c][p] = Σk data_i[p+k]·w[c][row][k]`.
  - Products are DW+WW bits.
  - Sums use full width ACC_W = DW+WW+clog2(K·K) (25 at the defaults).
- S2 (pass): `ps[c][p] += rs`. The accumulation restarts at row 0.
- When the row K-1 result reaches S2, compute `sc = ps_final >>> FRAC` (arithmetic shift, floor).
  - Base is 0 if first_i was set; otherwise it is buf[addr][c][p].
  - Not last: `buf[addr] ← sat_BUF_W(base + sc)`. No output is produced.
  - Last: `v = base + sc + sext(bias_i[c])`. If relu_en_i and v<0, v=0. Then `out_o ← sat_OUT_W(v)`, i.e. clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1], and out_valid_o is set.
- Flow control: `adv = !(out_valid_o && !out_ready_i)`.
  - in_ready_o = adv.
  - S1, S2 and the row counter update only when adv.
  - out_valid_o clears on a handshake unless a new final result loads on the same edge. A new result may load on the handshake edge (back-to-back).
- clear_i takes priority over beats:
  - row←0; S1/S2 valids, ps and out_valid_o←0.
  - The buffer is untouched, and no output or buffer write results from the aborted pass.
- The buffer is not reset. Its contents are undefined until written by a pass with first_i=1.

## Timing
- Reset values: in_ready_o=1, out_valid_o=0, out_o=0; row=0; all pipeline valids 0.
- Latency: final pass row K-1 accepted at edge E → out_valid_o=1 after edge E+2.
- Throughput: one beat per cycle with out_ready_i=1. Passes may be issued back-to-back with no bubble.
- Buffer read/write hazard: a pass on the same addr immediately following a non-last pass sees the updated value. The write happens at E+2 and is read at the next pass's row K-1 at ≥E+K.
- rst_i asserted mid-pass: all state clears immediately and asynchronously. The first beat after release is treated as row 0.
- clear_i and in_valid_i in the same cycle: the beat is dropped and in_ready_o stays 1.

## Test plan
- Single pass, first=last=1, data all 256, channel-0 weights all 1, bias 3 → out ch0 = 25+3 = 28 on both PEs, 2 cycles after beat 5.
- Pass A (first=1, last=0, addr 4, weights 2, data 256) then pass B (first=0, last=1, addr 4, weights 1, bias 0) → no output after A; output 75 after B.
- Saturation, data 2047:
  - weights 127 → 2047.
  - weights -128 → -2048.
  - weights -128 with relu_en_i=1 → 0.
- Backpressure: hold out_ready_i=0 for 3 cycles while a result is valid → in_ready_o=0, out_o stable, no beat lost. The next result is correct after release.
- clear_i after row 2 of a pass, then a full new pass with data 256 and weights 1 → exactly one output, value 25.
- rst_i pulse mid-pass, asynchronous between clock edges → out_valid_o=0 and in_ready_o=1 immediately. A following full pass gives the correct result.

Source files
------------

// File: rtl/conv_pe_array_p.sv
`default_nettype none
// ============================================================================
// Module   : conv_pe_array_p
// Brief    : Parametrised convolution PE array (N_CH channels x N_PE output
//            positions, KxK kernel). Kernel rows stream one per beat; an
//            addressable partial-sum buffer accumulates input-channel passes;
//            the final pass adds bias, applies optional ReLU and saturates.
// Revision : 1.0 - initial release
// ============================================================================
module conv_pe_array_p #(
    parameter int N_CH  = 3,
    parameter int N_PE  = 2,
    parameter int K     = 5,
    parameter int DW    = 12,
    parameter int WW    = 8,
    parameter int FRAC  = 8,
    parameter int OUT_W = 12,
    parameter int BUF_W = 20,
    parameter int DEPTH = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                clear_i,
    input  logic                                relu_en_i,
    input  logic                                in_valid_i,
    output logic                                in_ready_o,
    input  logic [(N_PE+K-1)*DW-1:0]            data_i,
    input  logic [N_CH*K*K*WW-1:0]              weight_i,
    input  logic [N_CH*WW-1:0]                  bias_i,
    input  logic                                first_i,
    input  logic                                last_i,
    input  logic [$clog2(DEPTH)-1:0]            addr_i,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [N_CH*N_PE*OUT_W-1:0]          out_o
);

    localparam int NX    = N_PE + K - 1;
    localparam int PW    = DW + WW;
    localparam int ACC_W = DW + WW + $clog2(K * K);
    localparam int RW    = (K > 1) ? $clog2(K) : 1;
    localparam int AW    = $clog2(DEPTH);
    // Headroom for base + pass sum + bias before saturation.
    localparam int SW    = ((ACC_W > BUF_W) ? ACC_W : BUF_W) + 2;

    localparam logic signed [SW-1:0] c_buf_max = {{(SW-BUF_W+1){1'b0}}, {(BUF_W-1){1'b1}}};
    localparam logic signed [SW-1:0] c_buf_min = {{(SW-BUF_W+1){1'b1}}, {(BUF_W-1){1'b0}}};
    localparam logic signed [SW-1:0] c_out_max = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] c_out_min = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // One kernel row dotted with the input slice for channel c, position p.
    function automatic logic signed [ACC_W-1:0] row_sum(
        input logic [NX*DW-1:0]       d,
        input logic [N_CH*K*K*WW-1:0] w,
        input logic [RW-1:0]          r,
        input int                     c,
        input int                     p
    );
        logic signed [ACC_W-1:0] acc;
        logic signed [DW-1:0]    dv;
        logic signed [WW-1:0]    wv;
        logic signed [PW-1:0]    prod;
        acc = '0;
        for (int k = 0; k < K; k++) begin
            dv   = d[(p+k)*DW +: DW];
            wv   = w[((c*K + int'(r))*K + k)*WW +: WW];
            prod = PW'(dv) * PW'(wv);
            acc  = acc + ACC_W'(prod);
        end
        return acc;
    endfunction

    // Scaled pass sum on top of either zero or the stored partial sum.
    function automatic logic signed [SW-1:0] pass_total(
        input logic signed [ACC_W-1:0] ps,
        input logic signed [BUF_W-1:0] bufv,
        input logic                    first
    );
        logic signed [ACC_W-1:0] sc;
        logic signed [SW-1:0]    base;
        sc = ps >>> FRAC;
        if (first) base = '0;
        else       base = SW'(bufv);
        return base + SW'(sc);
    endfunction

    function automatic logic signed [BUF_W-1:0] sat_buf(input logic signed [SW-1:0] v);
        if (v > c_buf_max)      return c_buf_max[BUF_W-1:0];
        else if (v < c_buf_min) return c_buf_min[BUF_W-1:0];
        else                    return v[BUF_W-1:0];
    endfunction

    // Bias, optional ReLU, then clamp to the output range.
    function automatic logic signed [OUT_W-1:0] final_val(
        input logic signed [SW-1:0] sum,
        input logic signed [WW-1:0] b,
        input logic                 relu
    );
        logic signed [SW-1:0] v;
        v = sum + SW'(b);
        if (relu && (v < 0)) v = '0;
        if (v > c_out_max)      return c_out_max[OUT_W-1:0];
        else if (v < c_out_min) return c_out_min[OUT_W-1:0];
        else                    return v[OUT_W-1:0];
    endfunction

    // Control state
    logic [RW-1:0] r_row;
    logic          r_sb_first, r_sb_last;
    logic [AW-1:0] r_sb_addr;
    logic          r_s1_valid, r_s1_row0, r_s1_end, r_s1_first, r_s1_last;
    logic [AW-1:0] r_s1_addr;
    logic          r_s2_valid, r_s2_first, r_s2_last;
    logic [AW-1:0] r_s2_addr;
    logic          r_out_valid;

    // Datapath state
    logic signed [ACC_W-1:0] r_rs  [N_CH][N_PE];
    logic signed [ACC_W-1:0] r_ps  [N_CH][N_PE];
    logic signed [OUT_W-1:0] r_out [N_CH][N_PE];
    logic signed [BUF_W-1:0] r_buf [DEPTH][N_CH][N_PE];

    logic signed [ACC_W-1:0] w_rs       [N_CH][N_PE];
    logic signed [BUF_W-1:0] w_buf_next [N_CH][N_PE];
    logic signed [OUT_W-1:0] w_out_next [N_CH][N_PE];

    logic          w_adv, w_accept, w_row0, w_row_end, w_first, w_last;
    logic [AW-1:0] w_addr;
    logic          w_fin, w_load, w_wr;

    assign w_adv     = !(r_out_valid && !out_ready_i);
    assign w_accept  = in_valid_i && w_adv && !clear_i;
    assign w_row0    = (r_row == '0);
    assign w_row_end = (r_row == RW'(K-1));
    // Sideband is only sampled on row 0; later rows reuse the captured copy.
    assign w_first   = w_row0 ? first_i : r_sb_first;
    assign w_last    = w_row0 ? last_i  : r_sb_last;
    assign w_addr    = w_row0 ? addr_i  : r_sb_addr;
    assign w_fin     = r_s2_valid && w_adv && !clear_i;
    assign w_load    = w_fin && r_s2_last;
    assign w_wr      = w_fin && !r_s2_last;

    assign in_ready_o  = w_adv;
    assign out_valid_o = r_out_valid;

    // Row MAC for every channel/position using the current row's weights
    always_comb begin
        for (int c = 0; c < N_CH; c++)
            for (int p = 0; p < N_PE; p++)
                w_rs[c][p] = row_sum(data_i, weight_i, r_row, c, p);
    end

    // Completion arithmetic for the pass sitting in S2
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            for (int p = 0; p < N_PE; p++) begin
                w_buf_next[c][p] = sat_buf(pass_total(r_ps[c][p], r_buf[r_s2_addr][c][p], r_s2_first));
                w_out_next[c][p] = final_val(pass_total(r_ps[c][p], r_buf[r_s2_addr][c][p], r_s2_first),
                                             bias_i[c*WW +: WW], relu_en_i);
            end
        end
    end

    // Row counter, pipeline valids, sideband tracking and output valid
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_row       <= '0;
            r_sb_first  <= 1'b0;
            r_sb_last   <= 1'b0;
            r_sb_addr   <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_row0   <= 1'b0;
            r_s1_end    <= 1'b0;
            r_s1_first  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_addr   <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_first  <= 1'b0;
            r_s2_last   <= 1'b0;
            r_s2_addr   <= '0;
            r_out_valid <= 1'b0;
        end else if (clear_i) begin
            r_row       <= '0;
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_row <= w_row_end ? '0 : r_row + RW'(1);
                if (w_row0) begin
                    r_sb_first <= first_i;
                    r_sb_last  <= last_i;
                    r_sb_addr  <= addr_i;
                end
            end
            if (w_adv) begin
                r_s1_valid <= w_accept;
                r_s1_row0  <= w_row0;
                r_s1_end   <= w_row_end;
                r_s1_first <= w_first;
                r_s1_last  <= w_last;
                r_s1_addr  <= w_addr;
                r_s2_valid <= r_s1_valid && r_s1_end;
                if (r_s1_valid && r_s1_end) begin
                    r_s2_first <= r_s1_first;
                    r_s2_last  <= r_s1_last;
                    r_s2_addr  <= r_s1_addr;
                end
            end
            if (w_load)           r_out_valid <= 1'b1;
            else if (out_ready_i) r_out_valid <= 1'b0;
        end
    end

    // Row sums, pass accumulators and output register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < N_CH; c++) begin
                for (int p = 0; p < N_PE; p++) begin
                    r_rs[c][p]  <= '0;
                    r_ps[c][p]  <= '0;
                    r_out[c][p] <= '0;
                end
            end
        end else if (clear_i) begin
            for (int c = 0; c < N_CH; c++)
                for (int p = 0; p < N_PE; p++)
                    r_ps[c][p] <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                for (int p = 0; p < N_PE; p++) begin
                    if (w_accept)
                        r_rs[c][p] <= w_rs[c][p];
                    if (w_adv && r_s1_valid)
                        r_ps[c][p] <= r_s1_row0 ? r_rs[c][p] : r_ps[c][p] + r_rs[c][p];
                    if (w_load)
                        r_out[c][p] <= w_out_next[c][p];
                end
            end
        end
    end

    // Partial-sum buffer: no reset, written only by completed non-final passes
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            for (int c = 0; c < N_CH; c++)
                for (int p = 0; p < N_PE; p++)
                    r_buf[r_s2_addr][c][p] <= w_buf_next[c][p];
        end
    end

    generate
        for (genvar gc = 0; gc < N_CH; gc++) begin : g_ch
            for (genvar gp = 0; gp < N_PE; gp++) begin : g_pe
                assign out_o[(gc*N_PE+gp)*OUT_W +: OUT_W] = r_out[gc][gp];
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_conv_pe_array_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_pe_array_p
// Brief    : Scoreboard bench for conv_pe_array_p with directed passes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_pe_array_p;

    localparam int N_CH  = 3;
    localparam int N_PE  = 2;
    localparam int K     = 5;
    localparam int DW    = 12;
    localparam int WW    = 8;
    localparam int FRAC  = 8;
    localparam int OUT_W = 12;
    localparam int BUF_W = 20;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int NX    = N_PE + K - 1;
    localparam int OV    = N_CH * N_PE * OUT_W;

    typedef logic [OV-1:0]    vec_t;
    typedef logic [NX*DW-1:0] dat_t;

    logic                   clk, rst_i, clear_i, relu_en_i;
    logic                   in_valid_i, in_ready_o;
    dat_t                   data_i;
    logic [N_CH*K*K*WW-1:0] weight_i;
    logic [N_CH*WW-1:0]     bias_i;
    logic                   first_i, last_i;
    logic [AW-1:0]          addr_i;
    logic                   out_valid_o, out_ready_i;
    vec_t                   out_o;

    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    conv_pe_array_p #(
        .N_CH(N_CH), .N_PE(N_PE), .K(K), .DW(DW), .WW(WW), .FRAC(FRAC),
        .OUT_W(OUT_W), .BUF_W(BUF_W), .DEPTH(DEPTH)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .clear_i    (clear_i),
        .relu_en_i  (relu_en_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .data_i     (data_i),
        .weight_i   (weight_i),
        .bias_i     (bias_i),
        .first_i    (first_i),
        .last_i     (last_i),
        .addr_i     (addr_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_o      (out_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vector: values ordered ch0p0, ch0p1, ch1p0, ch1p1, ch2p0, ch2p1.
    function automatic vec_t pk(input int a0, a1, b0, b1, c0, c1);
        vec_t v;
        int   vals[6];
        vals = '{a0, a1, b0, b1, c0, c1};
        for (int i = 0; i < 6; i++) v[i*OUT_W +: OUT_W] = OUT_W'(vals[i]);
        return v;
    endfunction

    function automatic dat_t data_const(input int v);
        dat_t d;
        for (int j = 0; j < NX; j++) d[j*DW +: DW] = DW'(v);
        return d;
    endfunction

    // Row- and position-dependent pattern: element j on row r = 256*r + 64*j.
    function automatic dat_t data_row(input int r);
        dat_t d;
        for (int j = 0; j < NX; j++) d[j*DW +: DW] = DW'(256*r + 64*j);
        return d;
    endfunction

    task automatic set_w(input int c, input int val);
        for (int r = 0; r < K; r++)
            for (int k = 0; k < K; k++)
                weight_i[((c*K + r)*K + k)*WW +: WW] = WW'(val);
    endtask

    task automatic set_b(input int c, input int val);
        bias_i[c*WW +: WW] = WW'(val);
    endtask

    task automatic chk(input string name, input vec_t act, input vec_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Present one beat, hold it until accepted (bounded), return just after the edge.
    task automatic beat(input logic f, input logic l, input logic [AW-1:0] a, input dat_t d);
        int n;
        @(negedge clk);
        data_i     = d;
        first_i    = f;
        last_i     = l;
        addr_i     = a;
        in_valid_i = 1'b1;
        n = 0;
        while (!in_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL beat_accept: in_ready stayed %0b, expected 1", in_ready_o);
        end
        @(posedge clk);
        #1 in_valid_i = 1'b0;
    endtask

    // Full pass; later rows carry inverted sideband, which must be ignored.
    task automatic run_pass(input logic f, input logic l, input logic [AW-1:0] a,
                            input int dmode, input bit push, input vec_t e);
        dat_t dd;
        if (push) exp_q.push_back(e);
        for (int r = 0; r < K; r++) begin
            dd = (dmode < 0) ? data_row(r) : data_const(dmode);
            if (r == 0) beat(f, l, a, dd);
            else        beat(!f, !l, ~a, dd);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake is compared against the scoreboard head
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            if (!rst_i && out_valid_o && out_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %h, expected none", out_o);
                end else begin
                    e = exp_q.pop_front();
                    if (out_o !== e) begin
                        errors++;
                        $display("FAIL out_value: got %h, expected %h", out_o, e);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_i       = 1'b1;
        clear_i     = 1'b0;
        relu_en_i   = 1'b0;
        in_valid_i  = 1'b0;
        data_i      = '0;
        weight_i    = '0;
        bias_i      = '0;
        first_i     = 1'b0;
        last_i      = 1'b0;
        addr_i      = '0;
        out_ready_i = 1'b1;
        #23 rst_i = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready",  vec_t'(in_ready_o),  vec_t'(1));
        chk("rst_out_valid", vec_t'(out_valid_o), vec_t'(0));
        chk("rst_out",       out_o,               '0);

        // Single pass with bias, plus latency check
        set_w(0, 1);  set_w(1, -1); set_w(2, 0);
        set_b(0, 3);  set_b(1, -5); set_b(2, 7);
        run_pass(1'b1, 1'b1, 4'd0, 256, 1'b1, pk(28, 28, -30, -30, 7, 7));
        @(negedge clk);
        @(negedge clk);
        chk("latency_e1", vec_t'(out_valid_o), vec_t'(0));
        @(negedge clk);
        chk("latency_e2", vec_t'(out_valid_o), vec_t'(1));
        drain();

        // Row/position alignment and floor shift
        bias_i   = '0;
        weight_i = '0;
        weight_i[((0*K + 1)*K + 3)*WW +: WW] = 8'sd1;
        weight_i[((1*K + 4)*K + 0)*WW +: WW] = -8'sd1;
        weight_i[((2*K + 0)*K + 4)*WW +: WW] = 8'sd3;
        run_pass(1'b1, 1'b1, 4'd0, -1, 1'b1, pk(1, 2, -4, -5, 3, 3));
        drain();

        // Buffer accumulation across passes, back-to-back same address
        weight_i = '0; set_w(0, 4);
        run_pass(1'b1, 1'b0, 4'd5, 256, 1'b0, '0);
        weight_i = '0; set_w(0, 2);
        run_pass(1'b1, 1'b0, 4'd4, 256, 1'b0, '0);
        weight_i = '0; set_w(0, 1);
        run_pass(1'b0, 1'b1, 4'd4, 256, 1'b1, pk(75, 75, 0, 0, 0, 0));
        weight_i = '0;
        run_pass(1'b0, 1'b1, 4'd5, 256, 1'b1, pk(100, 100, 0, 0, 0, 0));
        drain();

        // Saturation, with and without ReLU
        set_w(0, 127); set_w(1, -128); set_w(2, -128);
        run_pass(1'b1, 1'b1, 4'd0, 2047, 1'b1, pk(2047, 2047, -2048, -2048, -2048, -2048));
        drain();
        relu_en_i = 1'b1;
        run_pass(1'b1, 1'b1, 4'd0, 2047, 1'b1, pk(2047, 2047, 0, 0, 0, 0));
        drain();
        relu_en_i = 1'b0;

        // Backpressure: result held while a second pass waits
        weight_i = '0; set_w(0, 1);
        out_ready_i = 1'b0;
        run_pass(1'b1, 1'b1, 4'd0, 256, 1'b1, pk(25, 25, 0, 0, 0, 0));
        weight_i = '0; set_w(0, 3);
        fork
            run_pass(1'b1, 1'b1, 4'd0, 256, 1'b1, pk(75, 75, 0, 0, 0, 0));
        join_none
        n = 0;
        while (!out_valid_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", vec_t'(in_ready_o), vec_t'(0));
            chk("stall_out_hold", out_o, pk(25, 25, 0, 0, 0, 0));
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready_i = 1'b1;
        wait fork;
        drain();

        // Abort after three rows, then a clean pass
        weight_i = '0; set_w(0, 1);
        beat(1'b1, 1'b1, 4'd0, data_const(256));
        beat(1'b0, 1'b0, 4'd3, data_const(256));
        beat(1'b0, 1'b0, 4'd3, data_const(256));
        @(negedge clk);
        clear_i    = 1'b1;
        in_valid_i = 1'b1;
        #1 chk("clear_in_ready", vec_t'(in_ready_o), vec_t'(1));
        @(posedge clk);
        #1;
        clear_i    = 1'b0;
        in_valid_i = 1'b0;
        run_pass(1'b1, 1'b1, 4'd0, 256, 1'b1, pk(25, 25, 0, 0, 0, 0));
        drain();

        // Asynchronous reset while a result is stalled and a pass is partly in
        out_ready_i = 1'b0;
        run_pass(1'b1, 1'b1, 4'd0, 256, 1'b0, '0);
        beat(1'b1, 1'b1, 4'd0, data_const(256));
        beat(1'b0, 1'b0, 4'd0, data_const(256));
        @(negedge clk);
        chk("pre_rst_out_valid", vec_t'(out_valid_o), vec_t'(1));
        @(posedge clk);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_out_valid", vec_t'(out_valid_o), vec_t'(0));
        chk("async_rst_in_ready",  vec_t'(in_ready_o),  vec_t'(1));
        chk("async_rst_out",       out_o,               '0);
        out_ready_i = 1'b1;
        #3 rst_i = 1'b0;
        run_pass(1'b1, 1'b1, 4'd0, 256, 1'b1, pk(25, 25, 0, 0, 0, 0));
        drain();

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", vec_t'(exp_q.size()), vec_t'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
